pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/osc_pll_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 111 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pll_pkg.sv
// Shared FSM encoding and default timing for the PLL lock supervisor.
// STATS_EN mirrors the PLL_LOCK_STATS_EN build macro so other code can see which build is in use.
package osc_pll_pkg;

  typedef enum logic [1:0] {
    PLL_RESET   = 2'd0,
    WAIT_LOCK   = 2'd1,
    STABLE_WAIT = 2'd2,
    RUN         = 2'd3
  } pll_state_e;

  localparam int unsigned PLL_RST_CYC_DEF      = 240;
  localparam int unsigned LOCK_TIMEOUT_CYC_DEF = 240000;
  localparam int unsigned LOCK_STABLE_CYC_DEF  = 24000;

`ifdef PLL_LOCK_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; output lags input by two clk edges.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock, then releases sys_rst.
// Lock-loss / timeout counters are built only with PLL_LOCK_STATS_EN; otherwise those ports read 0.
module pll_lock_supervisor
  import osc_pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYC      = PLL_RST_CYC_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
  parameter int unsigned LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic [1:0] state,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] timeout_cnt
);

  localparam int unsigned CNT_W =
    $clog2(max3(PLL_RST_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC) + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             locked_s;

  sync_2ff u_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      PLL_RESET:   if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s)                state_d = STABLE_WAIT;
        else if (cnt_q == TMO_LAST)  state_d = PLL_RESET;
      end
      STABLE_WAIT: begin
        if (!locked_s)               state_d = WAIT_LOCK;
        else if (cnt_q == STB_LAST)  state_d = RUN;
      end
      RUN:         if (!locked_s) state_d = PLL_RESET;
      default:     state_d = PLL_RESET;
    endcase
    // Counter restarts on any transition and is parked while running so it never wraps.
    if (state_d != state_q)   cnt_d = '0;
    else if (state_q == RUN)  cnt_d = cnt_q;
  end

  // Outputs decode the next state so sys_rst asserts on the same edge a lock loss is acted on.
  always_comb begin
    pll_rst_d = (state_d == PLL_RESET);
    sys_rst_d = (state_d != RUN);
  end

  assign pll_rst = pll_rst_q;
  assign sys_rst = sys_rst_q;
  assign state   = state_q;

`ifdef PLL_LOCK_STATS_EN
  logic [7:0] loss_q;
  logic [7:0] tmo_q;
  logic       loss_evt;
  logic       tmo_evt;

  assign loss_evt = (state_q == RUN)       && (state_d == PLL_RESET);
  assign tmo_evt  = (state_q == WAIT_LOCK) && (state_d == PLL_RESET);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
      tmo_q  <= '0;
    end else begin
      if (loss_evt && (loss_q != 8'hFF)) loss_q <= loss_q + 8'd1;
      if (tmo_evt  && (tmo_q  != 8'hFF)) tmo_q  <= tmo_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
  assign timeout_cnt   = tmo_q;
`else
  assign lock_loss_cnt = '0;
  assign timeout_cnt   = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized and directed bench for pll_lock_supervisor against an elapsed-time reference model.
module tb_pll_lock_supervisor;
  import osc_pll_pkg::*;

  localparam int P_RST = 4;
  localparam int P_TMO = 20;
  localparam int P_STB = 8;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;
  logic [7:0] timeout_cnt;

  int total = 0;
  int bad = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYC      (P_RST),
    .LOCK_TIMEOUT_CYC (P_TMO),
    .LOCK_STABLE_CYC  (P_STB)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  always #5 refclk = ~refclk;

  // Model: phase plus the edge number it was entered on; the lock seen at edge n is the pin from edge n-2.
  int m_phase = 0, m_since = 0, m_edge = 0, m_loss = 0, m_tmo = 0;
  bit hist[$];

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_since <= 0; m_edge <= 0; m_loss <= 0; m_tmo <= 0;
      hist.delete();
    end else begin : step
      int e;
      bit ls;
      e  = m_edge + 1;
      ls = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(pll_locked);
      if (hist.size() > 4) void'(hist.pop_front());
      m_edge <= e;
      case (m_phase)
        0: if (e - m_since == P_RST) begin m_phase <= 1; m_since <= e; end
        1: begin
          if (ls) begin m_phase <= 2; m_since <= e; end
          else if (e - m_since == P_TMO) begin
            m_phase <= 0; m_since <= e;
            if (m_tmo < 255) m_tmo <= m_tmo + 1;
          end
        end
        2: begin
          if (!ls) begin m_phase <= 1; m_since <= e; end
          else if (e - m_since == P_STB) begin m_phase <= 3; m_since <= e; end
        end
        default: if (!ls) begin
          m_phase <= 0; m_since <= e;
          if (m_loss < 255) m_loss <= m_loss + 1;
        end
      endcase
    end
  end

  logic [1:0] exp_st;
  logic       exp_pr, exp_sr;
  logic [7:0] exp_ll, exp_to;
  assign exp_st = 2'(m_phase);
  assign exp_pr = (m_phase == 0);
  assign exp_sr = (m_phase != 3);
  assign exp_ll = STATS_EN ? 8'(m_loss) : 8'd0;
  assign exp_to = STATS_EN ? 8'(m_tmo) : 8'd0;

  task automatic apply_reset();
    @(negedge refclk);
    rst = 1'b1;
    pll_locked = 1'b0;
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    bit done;
    pll_locked = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({state, pll_rst, sys_rst, lock_loss_cnt, timeout_cnt} !== {2'd0, 1'b1, 1'b1, 8'd0, 8'd0})
      begin bad++; $display("FAIL reset_values got st=%0d pr=%0b sr=%0b ll=%0d to=%0d want 0 1 1 0 0",
                            state, pll_rst, sys_rst, lock_loss_cnt, timeout_cnt); end
    @(negedge refclk);
    rst = 1'b0;
    k = 0; done = 0;
    while (!done && k < 20) begin
      @(posedge refclk); k++; @(negedge refclk);
      if (!pll_rst) done = 1;
    end
    total++;
    if (!done || k != P_RST)
      begin bad++; $display("FAIL reset_pulse_len got %0d edges want %0d", k, P_RST); end
    total++;
    if (state !== 2'd1) begin bad++; $display("FAIL reset_to_wait got st=%0d want 1", state); end
  endtask

  task automatic test_lock_release();
    int k;
    bit done, saw_pr;
    apply_reset();
    k = 0;
    while (pll_rst && k < 20) begin @(negedge refclk); k++; end
    repeat (5) @(negedge refclk);
    pll_locked = 1'b1;
    k = 0; done = 0; saw_pr = 0;
    while (!done && k < 40) begin
      @(posedge refclk); k++; @(negedge refclk);
      if (pll_rst) saw_pr = 1;
      if (!sys_rst) done = 1;
    end
    total++;
    if (!done || k != P_STB + 3)
      begin bad++; $display("FAIL release_latency got %0d edges want %0d", k, P_STB + 3); end
    total++;
    if (state !== 2'd3 || saw_pr)
      begin bad++; $display("FAIL release_state got st=%0d pr_seen=%0b want st=3 pr_seen=0", state, saw_pr); end
    total++;
    if ({state, pll_rst, sys_rst, lock_loss_cnt, timeout_cnt} !== {exp_st, exp_pr, exp_sr, exp_ll, exp_to})
      begin bad++; $display("FAIL release_model got st=%0d ll=%0d to=%0d want st=%0d ll=%0d to=%0d",
                            state, lock_loss_cnt, timeout_cnt, exp_st, exp_ll, exp_to); end
  endtask

  task automatic test_timeout();
    localparam int NCYC = 6200;
    int rises[$];
    int falls[$];
    bit prev;
    apply_reset();
    prev = pll_rst;
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge refclk);
      if (pll_rst && !prev) rises.push_back(c);
      if (!pll_rst && prev && rises.size() > 0) falls.push_back(c);
      prev = pll_rst;
      total++;
      if ({state, pll_rst, sys_rst, lock_loss_cnt, timeout_cnt} !== {exp_st, exp_pr, exp_sr, exp_ll, exp_to})
        begin bad++; $display("FAIL timeout_model c=%0d got st=%0d pr=%0b sr=%0b to=%0d want st=%0d pr=%0b sr=%0b to=%0d",
                              c, state, pll_rst, sys_rst, timeout_cnt, exp_st, exp_pr, exp_sr, exp_to); end
    end
    total++;
    if (rises.size() != NCYC / (P_RST + P_TMO))
      begin bad++; $display("FAIL timeout_pulses got %0d want %0d", rises.size(), NCYC / (P_RST + P_TMO)); end
    if (rises.size() >= 3 && falls.size() >= 1) begin
      total++;
      if (rises[1] - rises[0] != P_RST + P_TMO || rises[2] - rises[1] != P_RST + P_TMO)
        begin bad++; $display("FAIL timeout_period got %0d/%0d want %0d",
                              rises[1] - rises[0], rises[2] - rises[1], P_RST + P_TMO); end
      total++;
      if (falls[0] - rises[0] != P_RST)
        begin bad++; $display("FAIL timeout_width got %0d want %0d", falls[0] - rises[0], P_RST); end
    end
    total++;
    if (timeout_cnt !== (STATS_EN ? 8'd255 : 8'd0))
      begin bad++; $display("FAIL timeout_saturate got %0d want %0d", timeout_cnt, STATS_EN ? 255 : 0); end
  endtask

  task automatic test_stable_glitch();
    int k;
    bit done, saw_pr, saw_rel;
    apply_reset();
    k = 0;
    while (pll_rst && k < 20) begin @(negedge refclk); k++; end
    repeat (2) @(negedge refclk);
    pll_locked = 1'b1;
    k = 0;
    while (state !== 2'd2 && k < 10) begin @(negedge refclk); k++; end
    total++;
    if (state !== 2'd2) begin bad++; $display("FAIL glitch_enter got st=%0d want 2", state); end
    repeat (5) @(negedge refclk);
    pll_locked = 1'b0;
    saw_pr = 0; saw_rel = 0;
    repeat (6) begin
      @(negedge refclk);
      if (pll_rst) saw_pr = 1;
      if (!sys_rst) saw_rel = 1;
    end
    total++;
    if (state !== 2'd1 || saw_pr || saw_rel)
      begin bad++; $display("FAIL glitch_drop got st=%0d pr_seen=%0b rel_seen=%0b want 1 0 0", state, saw_pr, saw_rel); end
    pll_locked = 1'b1;
    k = 0; done = 0;
    while (!done && k < 40) begin
      @(posedge refclk); k++; @(negedge refclk);
      if (!sys_rst) done = 1;
    end
    total++;
    if (!done || k != P_STB + 3 || state !== 2'd3)
      begin bad++; $display("FAIL glitch_relock got %0d edges st=%0d want %0d st=3", k, state, P_STB + 3); end
  endtask

  task automatic test_lock_loss();
    int k;
    bit done;
    pll_locked = 1'b0;
    k = 0; done = 0;
    while (!done && k < 10) begin
      @(posedge refclk); k++; @(negedge refclk);
      if (sys_rst) done = 1;
    end
    total++;
    if (!done || k != 3 || state !== 2'd0 || pll_rst !== 1'b1)
      begin bad++; $display("FAIL loss_latency got %0d edges st=%0d pr=%0b want 3 st=0 pr=1", k, state, pll_rst); end
    k = 0; done = 0;
    while (!done && k < 20) begin
      @(posedge refclk); k++; @(negedge refclk);
      if (!pll_rst) done = 1;
    end
    total++;
    if (!done || k != P_RST)
      begin bad++; $display("FAIL loss_pulse got %0d want %0d", k, P_RST); end
    total++;
    if (lock_loss_cnt !== (STATS_EN ? 8'd1 : 8'd0))
      begin bad++; $display("FAIL loss_count got %0d want %0d", lock_loss_cnt, STATS_EN ? 1 : 0); end
    pll_locked = 1'b1;
    k = 0;
    while (sys_rst && k < 40) begin @(negedge refclk); k++; end
    total++;
    if (sys_rst !== 1'b0 || state !== 2'd3)
      begin bad++; $display("FAIL loss_relock got sr=%0b st=%0d want 0 3", sys_rst, state); end
  endtask

  task automatic test_async_reset();
    int k;
    apply_reset();
    pll_locked = 1'b1;
    k = 0;
    while (state !== 2'd2 && k < 20) begin @(negedge refclk); k++; end
    total++;
    if (state !== 2'd2) begin bad++; $display("FAIL async_setup got st=%0d want 2", state); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({state, pll_rst, sys_rst, lock_loss_cnt, timeout_cnt} !== {2'd0, 1'b1, 1'b1, 8'd0, 8'd0})
      begin bad++; $display("FAIL async_reset got st=%0d pr=%0b sr=%0b ll=%0d to=%0d want 0 1 1 0 0",
                            state, pll_rst, sys_rst, lock_loss_cnt, timeout_cnt); end
    @(negedge refclk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge refclk);
      total++;
      if ({state, pll_rst, sys_rst} !== {exp_st, exp_pr, exp_sr})
        begin bad++; $display("FAIL async_recover got st=%0d pr=%0b sr=%0b want %0d %0b %0b",
                              state, pll_rst, sys_rst, exp_st, exp_pr, exp_sr); end
    end
  endtask

  task automatic test_random();
    int run;
    apply_reset();
    run = 0;
    for (int c = 0; c < 2500; c++) begin
      if (run == 0) begin
        pll_locked = ~pll_locked;
        run = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 30);
      end
      run--;
      @(negedge refclk);
      total++;
      if ({state, pll_rst, sys_rst, lock_loss_cnt, timeout_cnt} !== {exp_st, exp_pr, exp_sr, exp_ll, exp_to})
        begin bad++; $display("FAIL random_model c=%0d got st=%0d pr=%0b sr=%0b ll=%0d to=%0d want st=%0d pr=%0b sr=%0b ll=%0d to=%0d",
                              c, state, pll_rst, sys_rst, lock_loss_cnt, timeout_cnt,
                              exp_st, exp_pr, exp_sr, exp_ll, exp_to); end
    end
  endtask

  initial begin
    test_reset();
    test_lock_release();
    test_timeout();
    test_stable_glitch();
    test_lock_loss();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
